// File: rtl/openmips_pkg.sv
// ---------------------------------------------------------------------------
// openmips_pkg
// Shared definitions for the openmips_core pipeline.
//   - Datapath widths (32-bit word, 5-bit register index)
//   - Reset level (active-low)
//   - Opcode / funct encodings for the logic subset
//   - ALU operation enum and the pipeline bundle structs
//   - alu_exec(): the EX-stage logic function
// ---------------------------------------------------------------------------
package openmips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Level of rst that holds the core in reset.
  localparam logic RST_ACTIVE = 1'b0;

  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes (inst[5:0])
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_OR  = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_NOR = 3'd4,
    ALU_LUI = 3'd5
  } alu_op_e;

  // ID/EX pipeline register: operands already resolved through forwarding.
  typedef struct packed {
    alu_op_e   alu_op;
    word_t     opa;
    word_t     opb;
    logic      we;
    reg_addr_t waddr;
  } id_ex_t;

  // Write-back bundle carried by EX/MEM and MEM/WB.
  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    word_t     wdata;
  } wb_bus_t;

  // LUI arrives with the shifted immediate already in opb.
  function automatic word_t alu_exec(input alu_op_e op, input word_t a, input word_t b);
    word_t res;
    res = '0;
    case (op)
      ALU_OR:  res = a | b;
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_LUI: res = b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/openmips_regfile.sv
// ---------------------------------------------------------------------------
// openmips_regfile
// 32 x 32-bit general purpose register file, two combinational read ports
// and one write port committed on the rising clock edge.
//   clk    : clock
//   rst    : synchronous active-low reset; suppresses the write in that cycle
//            (contents themselves are never cleared)
//   we     : write request from WB
//   waddr  : write register index
//   wdata  : write data
//   raddr  : two read indices (port 0, port 1)
//   rdata  : two read results
// $0 reads as zero and is never written. A read of the register being
// written in the same cycle returns the incoming data.
// ---------------------------------------------------------------------------
module openmips_regfile
  import openmips_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [REG_ADDR_W-1:0]        waddr,
  input  logic [WORD_W-1:0]            wdata,
  input  logic [1:0][REG_ADDR_W-1:0]   raddr,
  output logic [1:0][WORD_W-1:0]       rdata
);

  word_t regs_reg [NUM_REGS];
  logic  wr_en;

  // Writes to $0 are dropped here; the decoded we is still visible upstream.
  assign wr_en = we && (waddr != '0) && (rst != RST_ACTIVE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs_reg[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      word_t rd_word;
      always_comb begin
        rd_word = regs_reg[raddr[gi]];
        if (raddr[gi] == '0) begin
          rd_word = '0;
        end else if (wr_en && (waddr == raddr[gi])) begin
          rd_word = wdata;
        end
      end
      assign rdata[gi] = rd_word;
    end
  endgenerate

endmodule

// File: rtl/openmips_core.sv
// ---------------------------------------------------------------------------
// openmips_core
// Scalar in-order 5-stage (IF/ID/EX/MEM/WB) MIPS32 pipeline executing the
// logic-immediate (ORI/ANDI/XORI/LUI) and logic-register (AND/OR/XOR/NOR)
// subset. No stalls, no branches; full forwarding into the ID operand read.
//   clk        : clock
//   rst        : synchronous active-low reset
//   rom_data_i : instruction word at rom_addr_o (combinational ROM)
//   rom_addr_o : fetch byte address (PC)
//   rom_ce_o   : fetch enable; instruction is treated as NOP while low
//   wb_we_o    : debug, register write in this cycle (as decoded)
//   wb_waddr_o : debug, destination register
//   wb_wdata_o : debug, write data
// ---------------------------------------------------------------------------
module openmips_core
  import openmips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o
);

  // ---------------- IF ----------------
  word_t pc_reg, pc_next;
  logic  ce_reg;
  word_t fetch_inst;

  // The PC only starts advancing once the enable is up, so the first
  // fetched address after reset is RESET_PC.
  assign pc_next = ce_reg ? (pc_reg + 32'd4) : pc_reg;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      pc_reg <= RESET_PC;
      ce_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      ce_reg <= 1'b1;
    end
  end

  assign rom_addr_o = pc_reg;
  assign rom_ce_o   = ce_reg;
  assign fetch_inst = ce_reg ? rom_data_i : NOP_INST;

  // ---------------- Pipeline registers ----------------
  word_t   if_id_inst_reg;
  id_ex_t  id_ex_reg, id_ex_next;
  wb_bus_t ex_mem_reg, ex_mem_next;
  wb_bus_t mem_wb_reg;

  // ---------------- ID ----------------
  logic [5:0]  inst_op, inst_funct;
  reg_addr_t   inst_rs, inst_rt, inst_rd;
  logic [4:0]  inst_shamt;
  logic [15:0] inst_imm;

  assign inst_op    = if_id_inst_reg[31:26];
  assign inst_rs    = if_id_inst_reg[25:21];
  assign inst_rt    = if_id_inst_reg[20:16];
  assign inst_rd    = if_id_inst_reg[15:11];
  assign inst_shamt = if_id_inst_reg[10:6];
  assign inst_funct = if_id_inst_reg[5:0];
  assign inst_imm   = if_id_inst_reg[15:0];

  logic [1:0][REG_ADDR_W-1:0] rf_raddr;
  logic [1:0][WORD_W-1:0]     rf_rdata;
  logic [1:0][WORD_W-1:0]     opnd_val;
  word_t                      ex_result;

  assign rf_raddr[0] = inst_rs;
  assign rf_raddr[1] = inst_rt;

  openmips_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_wb_reg.we),
    .waddr (mem_wb_reg.waddr),
    .wdata (mem_wb_reg.wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // Operand forwarding: youngest producer wins. The WB stage is covered by
  // the register file write-through, so only EX and MEM are checked here.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      word_t fwd_val;
      always_comb begin
        fwd_val = rf_rdata[gi];
        if (id_ex_reg.we && (id_ex_reg.waddr != '0) &&
            (id_ex_reg.waddr == rf_raddr[gi])) begin
          fwd_val = ex_result;
        end else if (ex_mem_reg.we && (ex_mem_reg.waddr != '0) &&
                     (ex_mem_reg.waddr == rf_raddr[gi])) begin
          fwd_val = ex_mem_reg.wdata;
        end
      end
      assign opnd_val[gi] = fwd_val;
    end
  endgenerate

  always_comb begin
    id_ex_next.alu_op = ALU_NOP;
    id_ex_next.opa    = '0;
    id_ex_next.opb    = '0;
    id_ex_next.we     = 1'b0;
    id_ex_next.waddr  = '0;
    case (inst_op)
      OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
        id_ex_next.opa   = opnd_val[0];
        id_ex_next.opb   = {16'h0000, inst_imm};
        id_ex_next.we    = 1'b1;
        id_ex_next.waddr = inst_rt;
        case (inst_op)
          OP_ORI:  id_ex_next.alu_op = ALU_OR;
          OP_ANDI: id_ex_next.alu_op = ALU_AND;
          OP_XORI: id_ex_next.alu_op = ALU_XOR;
          default: begin
            id_ex_next.alu_op = ALU_LUI;
            id_ex_next.opa    = '0;
            id_ex_next.opb    = {inst_imm, 16'h0000};
          end
        endcase
      end
      OP_SPECIAL: begin
        if (inst_shamt == '0) begin
          case (inst_funct)
            FUNCT_AND: id_ex_next.alu_op = ALU_AND;
            FUNCT_OR:  id_ex_next.alu_op = ALU_OR;
            FUNCT_XOR: id_ex_next.alu_op = ALU_XOR;
            FUNCT_NOR: id_ex_next.alu_op = ALU_NOR;
            default:   id_ex_next.alu_op = ALU_NOP;
          endcase
          // Any unlisted funct (including the all-zero word) stays a NOP.
          if (id_ex_next.alu_op != ALU_NOP) begin
            id_ex_next.opa   = opnd_val[0];
            id_ex_next.opb   = opnd_val[1];
            id_ex_next.we    = 1'b1;
            id_ex_next.waddr = inst_rd;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- EX ----------------
  assign ex_result = alu_exec(id_ex_reg.alu_op, id_ex_reg.opa, id_ex_reg.opb);

  always_comb begin
    ex_mem_next.we    = id_ex_reg.we;
    ex_mem_next.waddr = id_ex_reg.waddr;
    ex_mem_next.wdata = ex_result;
  end

  // ---------------- Stage registers (MEM is a pass-through) ----------------
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      if_id_inst_reg <= NOP_INST;
      id_ex_reg      <= '0;
      ex_mem_reg     <= '0;
      mem_wb_reg     <= '0;
    end else begin
      if_id_inst_reg <= fetch_inst;
      id_ex_reg      <= id_ex_next;
      ex_mem_reg     <= ex_mem_next;
      mem_wb_reg     <= ex_mem_reg;
    end
  end

  // ---------------- WB debug view ----------------
  assign wb_we_o    = mem_wb_reg.we;
  assign wb_waddr_o = mem_wb_reg.waddr;
  assign wb_wdata_o = mem_wb_reg.wdata;

endmodule

// File: tb/tb_openmips_core.sv
// ---------------------------------------------------------------------------
// tb_openmips_core
// Directed tests for openmips_core with a combinational ROM model.
// Cycle 0 is the first cycle with rom_ce_o high after reset release; the
// instruction fetched in cycle k appears on the wb_* outputs in cycle k+4.
// ---------------------------------------------------------------------------
module tb_openmips_core;

  logic        clk;
  logic        rst;
  logic [31:0] rom_data_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] rom_mem [16];

  assign rom_data_i = (rom_addr_o[31:6] == 26'd0) ? rom_mem[rom_addr_o[5:2]] : 32'h0;

  openmips_core dut (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_data_i),
    .rom_addr_o (rom_addr_o),
    .rom_ce_o   (rom_ce_o),
    .wb_we_o    (wb_we_o),
    .wb_waddr_o (wb_waddr_o),
    .wb_wdata_o (wb_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom_mem[i] = 32'h0;
  endtask

  // Called at a negedge; returns at a negedge with rst just released.
  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h34011100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks_total++;
      if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || wb_we_o !== 1'b0) begin
        $display("FAIL reset_hold c%0d: ce=%b addr=%h we=%b, want ce=0 addr=0 we=0",
                 c, rom_ce_o, rom_addr_o, wb_we_o);
      end else checks_passed++;
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks_total++;
      if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'(c * 4)) begin
        $display("FAIL fetch_seq c%0d: ce=%b addr=%h, want ce=1 addr=%h",
                 c, rom_ce_o, rom_addr_o, 32'(c * 4));
      end else checks_passed++;
      if (c < 4) begin
        checks_total++;
        if (wb_we_o !== 1'b0) begin
          $display("FAIL early_wb c%0d: we=%b, want 0", c, wb_we_o);
        end else checks_passed++;
      end
      $display("reset c%0d addr=%h ce=%b we=%b", c, rom_addr_o, rom_ce_o, wb_we_o);
    end
  endtask

  // Independent ORIs followed by R-types that read through the register
  // file, the WB write-through and the MEM forward.
  task automatic test_ori();
    logic [4:0]  exp_addr [7];
    logic [31:0] exp_data [7];
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h34011100;  // ORI $1,$0,0x1100
    rom_mem[1] = 32'h34020020;  // ORI $2,$0,0x0020
    rom_mem[2] = 32'h3403FF00;  // ORI $3,$0,0xFF00
    rom_mem[3] = 32'h3404FFFF;  // ORI $4,$0,0xFFFF
    rom_mem[4] = 32'h00222826;  // XOR $5,$1,$2
    rom_mem[5] = 32'h00433025;  // OR  $6,$2,$3
    rom_mem[6] = 32'h00A43827;  // NOR $7,$5,$4
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    exp_data = '{32'h00001100, 32'h00000020, 32'h0000FF00, 32'h0000FFFF,
                 32'h00001120, 32'h0000FF20, 32'hFFFF0000};
    apply_reset(2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks_total++;
      if (c >= 4 && c < 11) begin
        if (wb_we_o !== 1'b1 || wb_waddr_o !== exp_addr[c-4] || wb_wdata_o !== exp_data[c-4]) begin
          $display("FAIL ori_wb c%0d: we=%b $%0d=%h, want we=1 $%0d=%h",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o, exp_addr[c-4], exp_data[c-4]);
        end else checks_passed++;
      end else begin
        if (wb_we_o !== 1'b0) begin
          $display("FAIL ori_idle c%0d: we=%b, want 0", c, wb_we_o);
        end else checks_passed++;
      end
      $display("ori c%0d we=%b $%0d=%h", c, wb_we_o, wb_waddr_o, wb_wdata_o);
    end
  endtask

  // Each ORI depends on the previous one through the EX forward.
  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h34011100;
    rom_mem[1] = 32'h34210020;
    rom_mem[2] = 32'h34214400;
    rom_mem[3] = 32'h34210044;
    exp_data = '{32'h00001100, 32'h00001120, 32'h00005520, 32'h00005564};
    apply_reset(2);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks_total++;
      if (c >= 4 && c < 8) begin
        if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd1 || wb_wdata_o !== exp_data[c-4]) begin
          $display("FAIL chain_wb c%0d: we=%b $%0d=%h, want we=1 $1=%h",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o, exp_data[c-4]);
        end else checks_passed++;
      end else begin
        if (wb_we_o !== 1'b0) begin
          $display("FAIL chain_idle c%0d: we=%b, want 0", c, wb_we_o);
        end else checks_passed++;
      end
      $display("chain c%0d we=%b $%0d=%h", c, wb_we_o, wb_waddr_o, wb_wdata_o);
    end
  endtask

  task automatic test_lui_rtype();
    logic [4:0]  exp_addr [6];
    logic [31:0] exp_data [6];
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h3C010101;  // LUI $1,0x0101
    rom_mem[1] = 32'h3402FFFF;  // ORI $2,$0,0xFFFF
    rom_mem[2] = 32'h00221824;  // AND $3,$1,$2
    rom_mem[3] = 32'h00221825;  // OR
    rom_mem[4] = 32'h00221826;  // XOR
    rom_mem[5] = 32'h00221827;  // NOR
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3};
    exp_data = '{32'h01010000, 32'h0000FFFF, 32'h00000000,
                 32'h0101FFFF, 32'h0101FFFF, 32'hFEFE0000};
    apply_reset(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        checks_total++;
        if (wb_we_o !== 1'b1 || wb_waddr_o !== exp_addr[c-4] || wb_wdata_o !== exp_data[c-4]) begin
          $display("FAIL lui_rtype c%0d: we=%b $%0d=%h, want we=1 $%0d=%h",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o, exp_addr[c-4], exp_data[c-4]);
        end else checks_passed++;
        $display("lui_rtype c%0d we=%b $%0d=%h", c, wb_we_o, wb_waddr_o, wb_wdata_o);
      end
    end
  endtask

  // Writes to $0 are reported but never reach later readers; NOP never writes.
  task automatic test_zero_nop();
    logic        exp_we   [5];
    logic [4:0]  exp_addr [5];
    logic [31:0] exp_data [5];
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h3400ABCD;  // ORI $0,$0,0xABCD
    rom_mem[1] = 32'h34050000;  // ORI $5,$0,0  ($0 producer in EX)
    rom_mem[2] = 32'h00000000;  // NOP
    rom_mem[3] = 32'h00003025;  // OR $6,$0,$0  ($0 producer in WB)
    rom_mem[4] = 32'h34070001;  // ORI $7,$0,1  ($0 from register file)
    exp_we   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_addr = '{5'd0, 5'd5, 5'd0, 5'd6, 5'd7};
    exp_data = '{32'h0000ABCD, 32'h0, 32'h0, 32'h0, 32'h00000001};
    apply_reset(2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 4 && c < 9) begin
        checks_total++;
        if (wb_we_o !== exp_we[c-4] ||
            (exp_we[c-4] && (wb_waddr_o !== exp_addr[c-4] || wb_wdata_o !== exp_data[c-4]))) begin
          $display("FAIL zero_nop c%0d: we=%b $%0d=%h, want we=%b $%0d=%h",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o, exp_we[c-4], exp_addr[c-4], exp_data[c-4]);
        end else checks_passed++;
        $display("zero_nop c%0d we=%b $%0d=%h", c, wb_we_o, wb_waddr_o, wb_wdata_o);
      end
    end
  endtask

  // One-cycle reset while the forwarding chain is in flight.
  task automatic test_midrun_reset();
    logic [31:0] exp_data [4];
    rst = 1'b0;
    clear_rom();
    rom_mem[0] = 32'h34011100;
    rom_mem[1] = 32'h34210020;
    rom_mem[2] = 32'h34214400;
    rom_mem[3] = 32'h34210044;
    exp_data = '{32'h00001100, 32'h00001120, 32'h00005520, 32'h00005564};
    apply_reset(2);
    for (int c = 0; c < 6; c++) @(negedge clk);
    // Now in cycle 5: instruction 1 on WB, instructions 2 and 3 in flight.
    checks_total++;
    if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h00001120) begin
      $display("FAIL midrun_pre: we=%b data=%h, want we=1 data=00001120", wb_we_o, wb_wdata_o);
    end else checks_passed++;
    rst = 1'b0;
    @(negedge clk);
    checks_total++;
    if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || wb_we_o !== 1'b0) begin
      $display("FAIL midrun_in_reset: ce=%b addr=%h we=%b, want 0/0/0",
               rom_ce_o, rom_addr_o, wb_we_o);
    end else checks_passed++;
    rst = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks_total++;
      if (rom_ce_o !== 1'b1 || rom_addr_o !== 32'(c * 4)) begin
        $display("FAIL midrun_fetch c%0d: ce=%b addr=%h, want ce=1 addr=%h",
                 c, rom_ce_o, rom_addr_o, 32'(c * 4));
      end else checks_passed++;
      checks_total++;
      if (c >= 4 && c < 8) begin
        if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd1 || wb_wdata_o !== exp_data[c-4]) begin
          $display("FAIL midrun_wb c%0d: we=%b $%0d=%h, want we=1 $1=%h",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o, exp_data[c-4]);
        end else checks_passed++;
      end else begin
        if (wb_we_o !== 1'b0) begin
          $display("FAIL midrun_stale c%0d: we=%b $%0d=%h, want we=0",
                   c, wb_we_o, wb_waddr_o, wb_wdata_o);
        end else checks_passed++;
      end
      $display("midrun c%0d addr=%h we=%b $%0d=%h", c, rom_addr_o, wb_we_o, wb_waddr_o, wb_wdata_o);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_rom();
    @(negedge clk);
    test_reset();
    test_ori();
    test_back_to_back();
    test_lui_rtype();
    test_zero_nop();
    test_midrun_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
